sobel_multi_thresh_adj: RTL and testbench

//  Next-generation key-driven threshold controller for the video processing chain. Keeps an

---
 rtl/sobel_multi_thresh_adj_pkg.sv | 24 ++
 rtl/sobel_multi_thresh_adj_key_repeat_fsm.sv | 95 +++++++++
 rtl/sobel_multi_thresh_adj.sv | 96 +++++++++
 tb/tb_sobel_multi_thresh_adj.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_multi_thresh_adj_pkg.sv
// Shared types and helpers for the key-driven threshold controller.
package sobel_multi_thresh_adj_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRESS  = 2'd1,
    REPEAT = 2'd2,
    BLOCK  = 2'd3
  } key_state_e;

  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_UP   = 2'd1;
  localparam logic [1:0] DIR_DN   = 2'd2;

  // grade -> threshold, evaluated wide then clamped to the threshold range
  function automatic int thr_map(input int g, input int base, input int step, input int thr_w);
    longint v;
    longint mx;
    v  = longint'(base) + longint'(g) * longint'(step);
    mx = (longint'(1) << thr_w) - 1;
    return int'((v > mx) ? mx : v);
  endfunction

endpackage

// File: rtl/sobel_multi_thresh_adj_key_repeat_fsm.sv
// Up/down key press detector with hold-to-repeat; emits one-cycle step pulses
// and passes channel-select requests only while no key is active.
module key_repeat_fsm
  import sobel_multi_thresh_adj_pkg::*;
#(
  parameter int REPEAT_DLY = 50_000_000,
  parameter int REPEAT_PER = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_up,
  input  logic key_dn,
  input  logic key_sel,
  output logic step_up,
  output logic step_dn,
  output logic sel_ok
);

  localparam int CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DLY_END = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0] PER_END = CNT_W'(REPEAT_PER - 1);

  key_state_e       state_q, state_d;
  logic [1:0]       dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       key_dir;
  logic             step;

  // state, held direction and hold counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dir_q   <= DIR_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state, counter and step/select decisions
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    step    = 1'b0;
    sel_ok  = 1'b0;
    key_dir = DIR_NONE;
    if (key_up && !key_dn)      key_dir = DIR_UP;
    else if (key_dn && !key_up) key_dir = DIR_DN;
    unique case (state_q)
      IDLE: begin
        sel_ok = key_sel;
        if (key_up && key_dn) begin
          state_d = BLOCK;
        end else if (key_dir != DIR_NONE) begin
          step    = 1'b1;
          dir_d   = key_dir;
          cnt_d   = '0;
          state_d = PRESS;
        end
      end
      PRESS, REPEAT: begin
        if (key_up && key_dn) begin
          state_d = BLOCK;
          dir_d   = DIR_NONE;
          cnt_d   = '0;
        end else if (key_dir == dir_q) begin
          if (cnt_q == ((state_q == PRESS) ? DLY_END : PER_END)) begin
            step    = 1'b1;
            cnt_d   = '0;
            state_d = REPEAT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          // released (or switched key without overlap): start over
          state_d = IDLE;
          dir_d   = DIR_NONE;
          cnt_d   = '0;
        end
      end
      BLOCK: begin
        if (!key_up && !key_dn) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign step_up = step && (dir_d == DIR_UP);
  assign step_dn = step && (dir_d == DIR_DN);

endmodule

// File: rtl/sobel_multi_thresh_adj.sv
// Per-channel grade registers, channel pointer and grade->threshold mapping
// driven by the key repeat FSM.
module sobel_multi_thresh_adj
  import sobel_multi_thresh_adj_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int GRADE_W    = 4,
  parameter int THR_W      = 8,
  parameter int GRADE_RST  = 8,
  parameter int THR_BASE   = 20,
  parameter int THR_STEP   = 5,
  parameter int REPEAT_DLY = 50_000_000,
  parameter int REPEAT_PER = 10_000_000,
  parameter int WRAP_EN    = 0,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      key_up,
  input  logic                      key_dn,
  input  logic                      key_sel,
  output logic [CH_W-1:0]           active_ch,
  output logic [NUM_CH*GRADE_W-1:0] grade,
  output logic [NUM_CH*THR_W-1:0]   threshold,
  output logic                      thr_upd
);

  localparam logic [GRADE_W-1:0] G_MAX   = '1;
  localparam logic [GRADE_W-1:0] G_RST   = GRADE_W'(GRADE_RST);
  localparam logic [THR_W-1:0]   THR_RST = THR_W'(thr_map(GRADE_RST, THR_BASE, THR_STEP, THR_W));
  localparam logic [CH_W-1:0]    CH_LAST = CH_W'(NUM_CH - 1);

  logic                             step_up, step_dn, sel_ok;
  logic [CH_W-1:0]                  ch_q, ch_d;
  logic [NUM_CH-1:0][GRADE_W-1:0]   grade_q;
  logic [NUM_CH-1:0][THR_W-1:0]     thr_q, thr_d;

  key_repeat_fsm #(
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER)
  ) u_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_up  (key_up),
    .key_dn  (key_dn),
    .key_sel (key_sel),
    .step_up (step_up),
    .step_dn (step_dn),
    .sel_ok  (sel_ok)
  );

  // channel advance happens before a same-cycle step, so the step targets ch_d
  always_comb begin
    ch_d = ch_q;
    if (sel_ok) ch_d = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
  end

  // active channel pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ch_q <= '0;
    else        ch_q <= ch_d;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // grade of channel i; only moves while it is the (new) active channel
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        grade_q[i] <= G_RST;
      end else if (ch_d == CH_W'(i)) begin
        if (step_up)
          grade_q[i] <= (grade_q[i] == G_MAX) ? ((WRAP_EN != 0) ? '0 : G_MAX) : grade_q[i] + 1'b1;
        else if (step_dn)
          grade_q[i] <= (grade_q[i] == '0) ? ((WRAP_EN != 0) ? G_MAX : '0) : grade_q[i] - 1'b1;
      end
    end

    assign thr_d[i] = THR_W'(thr_map(int'(grade_q[i]), THR_BASE, THR_STEP, THR_W));

    // registered threshold, one cycle behind the grade
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) thr_q[i] <= THR_RST;
      else        thr_q[i] <= thr_d[i];
    end
  end

  // pulse alongside any threshold change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) thr_upd <= 1'b0;
    else        thr_upd <= (thr_d != thr_q);
  end

  assign active_ch = ch_q;
  assign grade     = grade_q;
  assign threshold = thr_q;

endmodule

// File: tb/tb_sobel_multi_thresh_adj.sv
// Directed bench: a saturating DUT and a wrapping DUT, thr_upd pulses checked
// against a queue of expected threshold vectors.
module tb_sobel_multi_thresh_adj;
  import sobel_multi_thresh_adj_pkg::*;

  localparam int NCH = 4;
  localparam int GW  = 4;
  localparam int TW  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_up = 1'b0, key_dn = 1'b0, key_sel = 1'b0;
  logic key_up_b = 1'b0, key_dn_b = 1'b0, key_sel_b = 1'b0;
  logic [1:0]        active_ch, active_ch_b;
  logic [NCH*GW-1:0] grade, grade_b;
  logic [NCH*TW-1:0] threshold, threshold_b;
  logic              thr_upd, thr_upd_b;

  int checks = 0;
  int errors = 0;
  logic [NCH*TW-1:0] exp_q[$];
  logic [NCH*TW-1:0] mon_exp;
  int mg[NCH];
  int mch;

  always #5 clk = ~clk;

  sobel_multi_thresh_adj #(.REPEAT_DLY(8), .REPEAT_PER(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .key_up(key_up), .key_dn(key_dn), .key_sel(key_sel),
    .active_ch(active_ch), .grade(grade), .threshold(threshold), .thr_upd(thr_upd)
  );

  sobel_multi_thresh_adj #(.REPEAT_DLY(8), .REPEAT_PER(3), .WRAP_EN(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .key_up(key_up_b), .key_dn(key_dn_b), .key_sel(key_sel_b),
    .active_ch(active_ch_b), .grade(grade_b), .threshold(threshold_b), .thr_upd(thr_upd_b)
  );

  function automatic int exp_thr(input int g);
    int v;
    v = 20 + 5 * g;
    return (v > 255) ? 255 : v;
  endfunction

  function automatic logic [NCH*GW-1:0] pack_g();
    logic [NCH*GW-1:0] r;
    for (int i = 0; i < NCH; i++) r[i*GW +: GW] = GW'(mg[i]);
    return r;
  endfunction

  function automatic logic [NCH*TW-1:0] pack_t();
    logic [NCH*TW-1:0] r;
    for (int i = 0; i < NCH; i++) r[i*TW +: TW] = TW'(exp_thr(mg[i]));
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // saturating model step on the model's active channel; queue expected thresholds
  task automatic model_step(input bit up);
    int old;
    old = mg[mch];
    if (up) mg[mch] = (old == 15) ? 15 : old + 1;
    else    mg[mch] = (old == 0) ? 0 : old - 1;
    if (mg[mch] != old) exp_q.push_back(pack_t());
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) mg[i] = 8;
    mch = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    key_up = 1'b0; key_dn = 1'b0; key_sel = 1'b0;
    tick(2);
    rst_n = 1'b1;
    model_reset();
    tick(1);
  endtask

  // every thr_upd pulse of the saturating DUT consumes one expected vector
  always @(negedge clk) begin
    if (rst_n && thr_upd) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL thr_upd_unexpected: observed pulse expected none, threshold %0h", threshold);
      end
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        checks++;
        assert (threshold === mon_exp) else begin
          errors++;
          $error("FAIL thr_upd_value: observed %0h expected %0h", threshold, mon_exp);
        end
      end
    end
  end

  initial begin
    model_reset();
    // reset state
    tick(2);
    check("rst_grade", 64'(grade), 64'(16'h8888));
    check("rst_thr", 64'(threshold), 64'({4{8'd60}}));
    check("rst_ch", 64'(active_ch), 64'(0));
    check("rst_upd", 64'(thr_upd), 64'(0));
    rst_n = 1'b1;
    tick(1);

    // 1: reach REPEAT, then reset while the key is still held
    key_up = 1'b1;
    repeat (3) model_step(1'b1);
    tick(14);
    check("t1_grade0", 64'(grade[3:0]), 64'(11));
    check("t1_state", 64'(dut_a.u_fsm.state_q), 64'(REPEAT));
    check("t1_q_empty", 64'(exp_q.size()), 64'(0));
    rst_n = 1'b0;
    key_up = 1'b0;
    #1;
    check("t1_rst_grade", 64'(grade), 64'(16'h8888));
    check("t1_rst_thr", 64'(threshold), 64'({4{8'd60}}));
    check("t1_rst_ch", 64'(active_ch), 64'(0));
    check("t1_rst_state", 64'(dut_a.u_fsm.state_q), 64'(IDLE));
    tick(1);
    rst_n = 1'b1;
    model_reset();
    tick(1);

    // 2: two-cycle press gives exactly one step
    key_up = 1'b1;
    model_step(1'b1);
    tick(2);
    key_up = 1'b0;
    tick(3);
    check("t2_grade", 64'(grade), 64'(16'h8889));
    check("t2_thr", 64'(threshold), 64'(pack_t()));
    check("t2_thr0", 64'(threshold[7:0]), 64'(65));
    check("t2_q_empty", 64'(exp_q.size()), 64'(0));
    do_reset();

    // 3: long hold, auto-repeat then saturation at 15
    key_up = 1'b1;
    repeat (7) model_step(1'b1);
    tick(21);
    check("t3_grade0_14", 64'(grade[3:0]), 64'(14));
    tick(1);
    check("t3_thr0_90", 64'(threshold[7:0]), 64'(90));
    tick(11);
    check("t3_grade0_15", 64'(grade[3:0]), 64'(15));
    check("t3_thr0_95", 64'(threshold[7:0]), 64'(95));
    check("t3_others", 64'(grade[15:4]), 64'(12'h888));
    key_up = 1'b0;
    tick(3);
    check("t3_q_empty", 64'(exp_q.size()), 64'(0));
    do_reset();

    // 4: wrapping DUT, step down from 0 wraps to 15
    for (int i = 0; i < 8; i++) begin
      key_dn_b = 1'b1;
      tick(1);
      key_dn_b = 1'b0;
      tick(2);
    end
    check("t4_grade_0", 64'(grade_b), 64'(16'h8880));
    check("t4_thr_20", 64'(threshold_b[7:0]), 64'(20));
    key_dn_b = 1'b1;
    tick(1);
    key_dn_b = 1'b0;
    check("t4_wrap_grade", 64'(grade_b), 64'(16'h888F));
    tick(1);
    check("t4_wrap_thr", 64'(threshold_b[7:0]), 64'(95));
    check("t4_wrap_upd", 64'(thr_upd_b), 64'(1));

    // 5: channel select, step on channel 2, wrap the pointer, select+press together
    key_sel = 1'b1; tick(1); key_sel = 1'b0; mch = 1;
    check("t5_ch1", 64'(active_ch), 64'(1));
    key_sel = 1'b1; tick(1); key_sel = 1'b0; mch = 2;
    check("t5_ch2", 64'(active_ch), 64'(2));
    key_dn = 1'b1;
    model_step(1'b0);
    tick(1);
    key_dn = 1'b0;
    tick(3);
    check("t5_grade", 64'(grade), 64'(16'h8788));
    check("t5_thr", 64'(threshold), 64'(pack_t()));
    check("t5_thr2", 64'(threshold[23:16]), 64'(55));
    key_sel = 1'b1; tick(1); key_sel = 1'b0; tick(1);
    key_sel = 1'b1; tick(1); key_sel = 1'b0; mch = 0;
    check("t5_ch_wrap", 64'(active_ch), 64'(0));
    key_sel = 1'b1; key_up = 1'b1; mch = 1;
    model_step(1'b1);
    tick(1);
    key_sel = 1'b0; key_up = 1'b0;
    tick(3);
    check("t5_sel_press_ch", 64'(active_ch), 64'(1));
    check("t5_sel_press_grade", 64'(grade), 64'(pack_g()));

    // 6: both keys block; select dropped while pressed
    key_up = 1'b1; key_dn = 1'b1;
    tick(5);
    check("t6_block", 64'(dut_a.u_fsm.state_q), 64'(BLOCK));
    key_up = 1'b0;
    tick(4);
    check("t6_block_one_key", 64'(dut_a.u_fsm.state_q), 64'(BLOCK));
    check("t6_block_grade", 64'(grade), 64'(pack_g()));
    key_dn = 1'b0;
    tick(1);
    check("t6_idle", 64'(dut_a.u_fsm.state_q), 64'(IDLE));
    key_up = 1'b1;
    model_step(1'b1);
    tick(1);
    key_sel = 1'b1;
    tick(1);
    key_sel = 1'b0;
    check("t6_sel_dropped", 64'(active_ch), 64'(1));
    key_dn = 1'b1;
    tick(12);
    check("t6_join_block", 64'(dut_a.u_fsm.state_q), 64'(BLOCK));
    key_up = 1'b0; key_dn = 1'b0;
    tick(3);
    check("t6_grade", 64'(grade), 64'(pack_g()));
    check("t6_thr", 64'(threshold), 64'(pack_t()));
    check("t6_q_empty", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
